// File: rtl/control_pkg.sv
// Shared types and instruction-field positions for the control sequencer.
package control_pkg;

  // Sequencer states: IDLE waits for fetch, EXEC is the first (or only)
  // instruction cycle, MEM is the second cycle of memory/jump instructions.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2
  } state_t;

  localparam int IR_W     = 8;  // instruction register width
  localparam int LONG_BIT = 7;  // set: two-cycle (memory/jump) instruction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode: ir + cycle phase + carry -> datapath strobes.
// All outputs are forced to zero when en is low.
module control_decode
  import control_pkg::*;
#(
  parameter int SIG_SEL_W = 3,
  parameter int RS_W      = 2,
  parameter int ALU_W     = 4
) (
  input  logic [IR_W-1:0]         ir,
  input  logic                    cycle,
  input  logic                    carry,
  input  logic                    en,
  output logic                    M,
  output logic                    S,
  output logic                    J,
  output logic                    LJ,
  output logic                    CLI,
  output logic                    LJR,
  output logic                    MW,
  output logic                    MC,
  output logic                    RD,
  output logic                    WR,
  output logic                    Y,
  output logic                    WA,
  output logic                    ISP,
  output logic                    WC,
  output logic [RS_W-1:0]         RS,
  output logic [ALU_W-1:0]        ALU,
  output logic [2**SIG_SEL_W-1:0] SIG
);

  logic i7, i6, i5, i4, i3, i2, i1;
  logic m_raw, lj_raw, a_raw, isp_raw, low_grp, sig_grp;

  assign i7 = ir[7];
  assign i6 = ir[6];
  assign i5 = ir[5];
  assign i4 = ir[4];
  assign i3 = ir[3];
  assign i2 = ir[2];
  assign i1 = ir[1];

  // Shared product terms reused by several strobes.
  assign m_raw   = i7 & ~i6 & cycle;
  assign lj_raw  = ~i7 & ~i6 & ~i5 & i4 & ~i3;
  assign a_raw   = (i6 & ~i7) | (cycle & i6 & ~i5);
  assign isp_raw = ~i7 & ~i6 & i5;
  assign low_grp = ~i7 & ~i6 & ~i5 & ~i4;
  assign sig_grp = ~i7 & ~i6 & ~i5 & i4 & i3;

  // Gated strobe decode.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    M   = 1'b0;
    S   = 1'b0;
    J   = 1'b0;
    LJ  = 1'b0;
    CLI = 1'b0;
    LJR = 1'b0;
    MW  = 1'b0;
    MC  = 1'b0;
    RD  = 1'b0;
    WR  = 1'b0;
    Y   = 1'b0;
    WA  = 1'b0;
    ISP = 1'b0;
    WC  = 1'b0;
    RS  = '0;
    ALU = '0;
    SIG = '0;
    if (en) begin
      M   = m_raw;
      S   = i4;
      J   = i7 & i6 & i5 & cycle & ~(carry & i4);
      LJ  = lj_raw;
      CLI = lj_raw & i1;
      LJR = lj_raw & i2;
      MW  = m_raw & i5;
      MC  = i7 & ~cycle;
      RD  = low_grp & i2;
      WR  = low_grp & i3;
      Y   = i5;
      RS  = ir[RS_W-1:0];
      ISP = isp_raw;
      WA  = (m_raw & ~i5) | (a_raw & ~(i4 & ~i3));
      WC  = (a_raw | isp_raw) & i4;
      if (i6) ALU = ir[ALU_W-1:0];
      else    ALU[ALU_W-1] = ~i7;
      SIG[ir[SIG_SEL_W-1:0]] = sig_grp;
    end
  end

endmodule

// File: rtl/control_seq.sv
// Control sequencer: instruction register, IDLE/EXEC/MEM state machine with
// bounded memory wait-states and a sticky timeout fault.
// Optional interrupt vectoring enabled by defining CONTROL_IRQ_EN.
module control_seq
  import control_pkg::*;
#(
  parameter int SIG_SEL_W = 3,
  parameter int RS_W      = 2,
  parameter int ALU_W     = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              inst,
  input  logic                    inst_valid,
  output logic                    inst_ack,
  input  logic                    carry,
  input  logic                    mem_ready,
  input  logic                    irq,
  output logic                    cycle,
  output logic                    M,
  output logic                    S,
  output logic                    J,
  output logic                    LJ,
  output logic                    CLI,
  output logic                    LJR,
  output logic                    MW,
  output logic                    MC,
  output logic                    RD,
  output logic                    WR,
  output logic                    Y,
  output logic                    WA,
  output logic                    ISP,
  output logic                    WC,
  output logic [RS_W-1:0]         RS,
  output logic [ALU_W-1:0]        ALU,
  output logic [2**SIG_SEL_W-1:0] SIG,
  output logic                    fault,
  output logic                    irq_take
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [IR_W-1:0]   ir;
  logic [CNT_W-1:0]  wait_cnt;
  logic              fault_q;
  logic              accept_pt, ack_raw, take, load_ir;
  logic              cnt_clr, cnt_inc, set_fault;
  logic              irq_pend, in_mem, active;

  assign in_mem = (state == MEM);
  assign active = (state != IDLE) & ~rst;

  // Outputs are held at zero while reset is asserted.
  assign inst_ack = ack_raw & ~rst;
  assign irq_take = take & ~rst;
  assign cycle    = in_mem & ~rst;
  assign fault    = fault_q & ~rst;

  control_decode #(
    .SIG_SEL_W(SIG_SEL_W),
    .RS_W     (RS_W),
    .ALU_W    (ALU_W)
  ) u_decode (
    .ir   (ir),
    .cycle(in_mem),
    .carry(carry),
    .en   (active),
    .M    (M),
    .S    (S),
    .J    (J),
    .LJ   (LJ),
    .CLI  (CLI),
    .LJR  (LJR),
    .MW   (MW),
    .MC   (MC),
    .RD   (RD),
    .WR   (WR),
    .Y    (Y),
    .WA   (WA),
    .ISP  (ISP),
    .WC   (WC),
    .RS   (RS),
    .ALU  (ALU),
    .SIG  (SIG)
  );

`ifdef CONTROL_IRQ_EN
  logic ie;

  assign irq_pend = irq & ie;

  // Interrupt-enable flag: cleared on vectoring or CLI, set by LJR.
  always_ff @(posedge clk) begin
    if (rst)      ie <= 1'b1;
    else if (take) ie <= 1'b0;
    else if (LJR)  ie <= 1'b1;
    else if (CLI)  ie <= 1'b0;
  end
`else
  logic unused_irq;

  assign unused_irq = irq;
  assign irq_pend   = 1'b0;
`endif

  // Next-state logic: acceptance points, MEM wait handling and timeout.
  always_comb begin
    state_nxt = state;
    accept_pt = 1'b0;
    ack_raw   = 1'b0;
    take      = 1'b0;
    load_ir   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_fault = 1'b0;
    case (state)
      IDLE: accept_pt = 1'b1;
      EXEC: begin
        if (ir[LONG_BIT]) state_nxt = MEM;
        else              accept_pt = 1'b1;
      end
      MEM: begin
        // A ready on the timeout cycle still completes the access.
        if (mem_ready) begin
          accept_pt = 1'b1;
          cnt_clr   = 1'b1;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
          set_fault = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (accept_pt) begin
      if (irq_pend) begin
        take      = 1'b1;
        state_nxt = IDLE;
      end else begin
        ack_raw = 1'b1;
        if (inst_valid) begin
          load_ir   = 1'b1;
          state_nxt = EXEC;
        end else begin
          state_nxt = IDLE;
        end
      end
    end
  end

  // State, instruction register, wait counter and sticky fault.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      ir       <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_ir)      ir       <= inst;
      if (cnt_clr)      wait_cnt <= '0;
      else if (cnt_inc) wait_cnt <= wait_cnt + 1'b1;
      if (set_fault)    fault_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq: per-cycle expected outputs are queued
// as stimulus is driven and compared when the outputs are sampled.
// Covers the CONTROL_IRQ_EN build when that macro is defined.
module tb_control_seq;

  localparam int TO = 15;

  typedef struct packed {
    logic       cyc, ack, m, s, j, lj, cli, ljr, mw, mc, rd, wr, y, wa, isp, wc;
    logic [1:0] rs;
    logic [3:0] alu;
    logic [7:0] sig;
    logic       fault, take;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] inst = '0;
  logic       inst_valid = 1'b0, carry = 1'b0, mem_ready = 1'b0, irq = 1'b0;
  logic       inst_ack, cycle, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC;
  logic [1:0] RS;
  logic [3:0] ALU;
  logic [7:0] SIG;
  logic       fault, irq_take;

  obs_t obs;
  sb_t  sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  control_seq #(.SIG_SEL_W(3), .RS_W(2), .ALU_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid), .inst_ack(inst_ack),
    .carry(carry), .mem_ready(mem_ready), .irq(irq), .cycle(cycle),
    .M(M), .S(S), .J(J), .LJ(LJ), .CLI(CLI), .LJR(LJR), .MW(MW), .MC(MC),
    .RD(RD), .WR(WR), .Y(Y), .WA(WA), .ISP(ISP), .WC(WC),
    .RS(RS), .ALU(ALU), .SIG(SIG), .fault(fault), .irq_take(irq_take)
  );

  assign obs = {cycle, inst_ack, M, S, J, LJ, CLI, LJR, MW, MC, RD, WR, Y, WA, ISP, WC,
                RS, ALU, SIG, fault, irq_take};

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs just after the clock edge and queue its expectation.
  task automatic drive(input string tag, input logic r, input logic [7:0] i, input logic v,
                       input logic rdy, input logic cy, input logic iq, input obs_t e);
    sb_t ent;
    rst = r; inst = i; inst_valid = v; mem_ready = rdy; carry = cy; irq = iq;
    ent.tag = tag;
    ent.exp = e;
    sb.push_back(ent);
    @(posedge clk);
    #1;
  endtask

  // Compare sampled outputs against the queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin : pop_blk
        sb_t ent;
        ent = sb.pop_front();
        check(ent.tag, obs, ent.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d entries pending", sb.size());
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset and idle.
    drive("reset0", 1, 8'h00, 0, 0, 0, 0, obs_t'{default:0});
    drive("reset1", 1, 8'h41, 1, 1, 0, 0, obs_t'{default:0});
    drive("idle",   0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1});
    // Single-cycle ALU op 0x41.
    drive("idle_41", 0, 8'h41, 1, 0, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_41", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, wa:1, rs:2'd1, alu:4'h1});
    drive("idle_after_41", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1});
    // Memory write 0xA2 with immediate ready.
    drive("idle_a2", 0, 8'hA2, 1, 1, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_a2", 0, 8'h00, 0, 1, 0, 0, obs_t'{default:0, mc:1, y:1, rs:2'd2});
    drive("mem_a2",  0, 8'h00, 0, 1, 0, 0, obs_t'{default:0, cyc:1, ack:1, m:1, mw:1, y:1, rs:2'd2});
    // Conditional jump 0xF0, carry blocks then allows J; then back-to-back chain.
    drive("idle_f0", 0, 8'hF0, 1, 0, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_f0", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, s:1, mc:1, y:1});
    drive("mem_f0_c1", 0, 8'h00, 0, 0, 1, 0, obs_t'{default:0, cyc:1, s:1, y:1});
    drive("mem_f0_c0", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, cyc:1, s:1, y:1, j:1});
    drive("mem_f0_done", 0, 8'h1D, 1, 1, 0, 0, obs_t'{default:0, cyc:1, ack:1, s:1, y:1, j:1});
    drive("exec_1d", 0, 8'h41, 1, 0, 0, 0, obs_t'{default:0, ack:1, s:1, rs:2'd1, alu:4'h8, sig:8'h20});
    drive("exec_41b", 0, 8'h0C, 1, 0, 0, 0, obs_t'{default:0, ack:1, wa:1, rs:2'd1, alu:4'h1});
    drive("exec_0c", 0, 8'h30, 1, 0, 0, 0, obs_t'{default:0, ack:1, rd:1, wr:1, alu:4'h8});
    drive("exec_30", 0, 8'h50, 1, 0, 0, 0, obs_t'{default:0, ack:1, s:1, y:1, isp:1, wc:1, alu:4'h8});
    drive("exec_50", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, s:1, wc:1});
    // Ready arriving exactly on the timeout cycle completes without fault.
    drive("idle_80a", 0, 8'h80, 1, 0, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_80a", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, mc:1});
    for (int k = 0; k < TO; k++)
      drive("mem_wait_a", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, cyc:1, m:1, wa:1});
    drive("mem_ready_at_limit", 0, 8'h00, 0, 1, 0, 0, obs_t'{default:0, cyc:1, ack:1, m:1, wa:1});
    drive("idle_no_fault", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1});
    // Full timeout: fault is set and the instruction is abandoned.
    drive("idle_80b", 0, 8'h80, 1, 0, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_80b", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, mc:1});
    for (int k = 0; k <= TO; k++)
      drive("mem_wait_b", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, cyc:1, m:1, wa:1});
    drive("idle_fault",   0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, fault:1});
    drive("fault_sticky", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, fault:1});
    // Reset in the middle of MEM aborts and clears fault.
    drive("idle_a2_f", 0, 8'hA2, 1, 0, 0, 0, obs_t'{default:0, ack:1, fault:1});
    drive("exec_a2_f", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, mc:1, y:1, rs:2'd2, fault:1});
    drive("mem_a2_f",  0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, cyc:1, m:1, mw:1, y:1, rs:2'd2, fault:1});
    drive("rst_mid_mem", 1, 8'h00, 0, 0, 0, 0, obs_t'{default:0});
    drive("idle_after_rst", 0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1});
`ifdef CONTROL_IRQ_EN
    drive("irq_idle_take", 0, 8'h41, 1, 0, 0, 1, obs_t'{default:0, take:1});
    drive("irq_masked",    0, 8'h14, 1, 0, 0, 1, obs_t'{default:0, ack:1});
    drive("exec_14_ljr",   0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, s:1, lj:1, ljr:1, alu:4'h8});
    drive("irq_reenabled", 0, 8'h00, 0, 0, 0, 1, obs_t'{default:0, take:1});
    drive("idle_14",       0, 8'h14, 1, 0, 0, 0, obs_t'{default:0, ack:1});
    drive("exec_14b",      0, 8'h12, 1, 0, 0, 0, obs_t'{default:0, ack:1, s:1, lj:1, ljr:1, alu:4'h8});
    drive("exec_12_cli",   0, 8'h00, 0, 0, 0, 0, obs_t'{default:0, ack:1, s:1, lj:1, cli:1, rs:2'd2, alu:4'h8});
    drive("irq_after_cli", 0, 8'h00, 0, 0, 0, 1, obs_t'{default:0, ack:1});
`else
    drive("irq_ignored",   0, 8'h00, 0, 0, 0, 1, obs_t'{default:0, ack:1});
    drive("irq_exec_41",   0, 8'h41, 1, 0, 0, 1, obs_t'{default:0, ack:1});
    drive("exec_41_irq",   0, 8'h00, 0, 0, 0, 1, obs_t'{default:0, ack:1, wa:1, rs:2'd1, alu:4'h1});
`endif
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
